// File: rtl/stream_arbiter.sv
// Two-source stream arbiter: per-source FIFOs, round-robin grant into one output register, flush by ID.
// Define STREAM_ARB_STATS_EN to add saturating grant_cnt_1/grant_cnt_2/drop_cnt outputs.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module stream_arbiter #(
    parameter int ADDR_W = `ADDRESS_WIDTH,
    parameter int ID_W   = `ID_WIDTH,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_addr_1,
    input  logic [ID_W-1:0]   in_id_1,
    input  logic              in_valid_1,
    output logic              stall_1,
    input  logic              flush_1,
    input  logic [ID_W-1:0]   flush_id_1,
    input  logic [ADDR_W-1:0] in_addr_2,
    input  logic [ID_W-1:0]   in_id_2,
    input  logic              in_valid_2,
    output logic              stall_2,
    input  logic              flush_2,
    input  logic [ID_W-1:0]   flush_id_2,
    output logic [ADDR_W-1:0] out_address,
    output logic [ID_W-1:0]   out_id,
    output logic              out_src,
    output logic              out_valid,
`ifdef STREAM_ARB_STATS_EN
    output logic [15:0]       grant_cnt_1,
    output logic [15:0]       grant_cnt_2,
    output logic [15:0]       drop_cnt,
`endif
    input  logic              in_stall
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] in_addr  [2];
    logic [ID_W-1:0]   in_id    [2];
    logic              in_valid [2];
    logic              flush    [2];
    logic [ID_W-1:0]   flush_id [2];

    logic [ADDR_W-1:0] addr_mem_q [2][DEPTH];
    logic [ID_W-1:0]   id_mem_q   [2][DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [2], rd_ptr_d [2];
    logic [PTR_W-1:0]  wr_ptr_q [2], wr_ptr_d [2];
    logic [CNT_W-1:0]  count_q  [2], count_d  [2];

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic [ID_W-1:0]   out_id_q,    out_id_d;
    logic              out_src_q,   out_src_d;
    logic              rr_last_q,   rr_last_d;

    logic              full        [2];
    logic              accept      [2];
    logic              push        [2];
    logic              pop         [2];
    logic              eligible    [2];
    logic              out_hit     [2];
    logic              match_found [2];
    logic [CNT_W-1:0]  match_dist  [2];
    logic [PTR_W-1:0]  match_slot  [2];
    logic              load;
    logic              grant_v;
    logic              grant_src;

    assign in_addr[0]  = in_addr_1;
    assign in_addr[1]  = in_addr_2;
    assign in_id[0]    = in_id_1;
    assign in_id[1]    = in_id_2;
    assign in_valid[0] = in_valid_1;
    assign in_valid[1] = in_valid_2;
    assign flush[0]    = flush_1;
    assign flush[1]    = flush_2;
    assign flush_id[0] = flush_id_1;
    assign flush_id[1] = flush_id_2;

    assign stall_1     = full[0];
    assign stall_2     = full[1];
    assign out_valid   = out_valid_q;
    assign out_address = out_addr_q;
    assign out_id      = out_id_q;
    assign out_src     = out_src_q;

    // Flush search walks oldest to youngest so the first hit truncates the queue there.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            full[s]        = (count_q[s] == CNT_W'(DEPTH));
            accept[s]      = in_valid[s] && !full[s];
            match_found[s] = 1'b0;
            match_dist[s]  = '0;
            match_slot[s]  = '0;
            if (flush[s]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!match_found[s] && (CNT_W'(i) < count_q[s]) &&
                        (id_mem_q[s][rd_ptr_q[s] + PTR_W'(i)] == flush_id[s])) begin
                        match_found[s] = 1'b1;
                        match_dist[s]  = CNT_W'(i);
                        match_slot[s]  = rd_ptr_q[s] + PTR_W'(i);
                    end
                end
            end
            push[s]     = accept[s] && !(flush[s] && (match_found[s] || (in_id[s] == flush_id[s])));
            eligible[s] = (count_q[s] != '0) && !flush[s];
            out_hit[s]  = out_valid_q && flush[s] && (out_src_q == 1'(s)) && (out_id_q == flush_id[s]);
        end
    end

    always_comb begin
        load      = (!out_valid_q || !in_stall) && !(out_hit[0] || out_hit[1]);
        grant_v   = 1'b0;
        grant_src = 1'b0;
        if (load) begin
            if (eligible[0] && eligible[1]) begin
                grant_v   = 1'b1;
                grant_src = ~rr_last_q;
            end else if (eligible[0]) begin
                grant_v   = 1'b1;
                grant_src = 1'b0;
            end else if (eligible[1]) begin
                grant_v   = 1'b1;
                grant_src = 1'b1;
            end
        end
        rr_last_d = grant_v ? grant_src : rr_last_q;

        for (int s = 0; s < 2; s++) begin
            pop[s]      = grant_v && (grant_src == 1'(s));
            rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(pop[s]);
            wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(push[s]);
            count_d[s]  = count_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
            if (match_found[s]) begin
                wr_ptr_d[s] = match_slot[s];
                count_d[s]  = match_dist[s];
            end
        end

        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_id_d    = out_id_q;
        out_src_d   = out_src_q;
        if (out_hit[0] || out_hit[1]) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = grant_v;
            if (grant_v) begin
                out_addr_d = addr_mem_q[grant_src][rd_ptr_q[grant_src]];
                out_id_d   = id_mem_q[grant_src][rd_ptr_q[grant_src]];
                out_src_d  = grant_src;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                addr_mem_q[s][wr_ptr_q[s]] <= in_addr[s];
                id_mem_q[s][wr_ptr_q[s]]   <= in_id[s];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_id_q    <= '0;
            out_src_q   <= 1'b0;
            rr_last_q   <= 1'b1;
        end else begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr_q[s] <= rd_ptr_d[s];
                wr_ptr_q[s] <= wr_ptr_d[s];
                count_q[s]  <= count_d[s];
            end
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_id_q    <= out_id_d;
            out_src_q   <= out_src_d;
            rr_last_q   <= rr_last_d;
        end
    end

`ifdef STREAM_ARB_STATS_EN
    localparam int DROP_W = CNT_W + 2;

    logic [15:0]       grant_cnt_1_q, grant_cnt_2_q, drop_cnt_q;
    logic [DROP_W-1:0] drop_sum;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Flushed FIFO entries, dropped pushes and a flushed output register all count as drops.
    always_comb begin
        drop_sum = '0;
        for (int s = 0; s < 2; s++) begin
            if (match_found[s]) begin
                drop_sum = drop_sum + DROP_W'(count_q[s] - match_dist[s]);
            end
            drop_sum = drop_sum + DROP_W'(accept[s] && !push[s]) + DROP_W'(out_hit[s]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt_1_q <= '0;
            grant_cnt_2_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            grant_cnt_1_q <= sat_add(grant_cnt_1_q, 16'(pop[0]));
            grant_cnt_2_q <= sat_add(grant_cnt_2_q, 16'(pop[1]));
            drop_cnt_q    <= sat_add(drop_cnt_q, 16'(drop_sum));
        end
    end

    assign grant_cnt_1 = grant_cnt_1_q;
    assign grant_cnt_2 = grant_cnt_2_q;
    assign drop_cnt    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter: directed streams, stalls, flushes and reset, checked by a monitor.
// Counter outputs are checked when STREAM_ARB_STATS_EN is defined.
module tb_stream_arbiter;

    localparam int ADDR_W = 16;
    localparam int ID_W   = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] in_addr_1, in_addr_2;
    logic [ID_W-1:0]   in_id_1, in_id_2;
    logic              in_valid_1, in_valid_2;
    logic              stall_1, stall_2;
    logic              flush_1, flush_2;
    logic [ID_W-1:0]   flush_id_1, flush_id_2;
    logic [ADDR_W-1:0] out_address;
    logic [ID_W-1:0]   out_id;
    logic              out_src;
    logic              out_valid;
    logic              in_stall;
`ifdef STREAM_ARB_STATS_EN
    logic [15:0]       grant_cnt_1, grant_cnt_2, drop_cnt;
`endif

    stream_arbiter #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_addr_1(in_addr_1), .in_id_1(in_id_1), .in_valid_1(in_valid_1), .stall_1(stall_1),
        .flush_1(flush_1), .flush_id_1(flush_id_1),
        .in_addr_2(in_addr_2), .in_id_2(in_id_2), .in_valid_2(in_valid_2), .stall_2(stall_2),
        .flush_2(flush_2), .flush_id_2(flush_id_2),
        .out_address(out_address), .out_id(out_id), .out_src(out_src), .out_valid(out_valid),
`ifdef STREAM_ARB_STATS_EN
        .grant_cnt_1(grant_cnt_1), .grant_cnt_2(grant_cnt_2), .drop_cnt(drop_cnt),
`endif
        .in_stall(in_stall)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           cyc      = 0;
    logic [7:0]   exp_q[$];
    int           xfer_cyc[$];

    function automatic logic [15:0] addr_of(input logic [7:0] id);
        return {~id, id};
    endfunction

    function automatic logic [31:0] pack_exp(input logic [7:0] id);
        logic src;
        src = (id[7:4] == 4'h2);
        return {7'd0, src, addr_of(id), id};
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [7:0] id);
        in_valid_1 = v;
        in_id_1    = id;
        in_addr_1  = addr_of(id);
    endtask

    task automatic drive2(input logic v, input logic [7:0] id);
        in_valid_2 = v;
        in_id_2    = id;
        in_addr_2  = addr_of(id);
    endtask

    task automatic idle_inputs();
        drive1(1'b0, 8'h00);
        drive2(1'b0, 8'h00);
        flush_1 = 1'b0; flush_id_1 = 8'h00;
        flush_2 = 1'b0; flush_id_2 = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        in_stall = 1'b0;
        tick();
        tick();
        exp_q.delete();
        xfer_cyc.delete();
        reset = 1'b0;
        tick();
    endtask

    task automatic expect_ids(input logic [7:0] ids[$]);
        foreach (ids[k]) exp_q.push_back(ids[k]);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(exp_q.size() == 0, name, exp_q.size(), 0);
    endtask

    // Monitor: every consumer transfer must match the head of the expected queue.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (!reset && out_valid && !in_stall) begin
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_xfer", {7'd0, out_src, out_address, out_id}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check({7'd0, out_src, out_address, out_id} == pack_exp(e), "xfer",
                      {7'd0, out_src, out_address, out_id}, pack_exp(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit stall_seen;
        int acc1, acc2;
        bit a1, a2;

        idle_inputs();
        in_stall = 1'b0;
        reset    = 1'b1;
        #2;
        check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        check(out_id == '0, "rst_out_id", out_id, 0);
        check(out_address == '0, "rst_out_address", out_address, 0);
        check(out_src == 1'b0, "rst_out_src", out_src, 0);
        check(stall_1 == 1'b0 && stall_2 == 1'b0, "rst_stall", {stall_1, stall_2}, 0);
`ifdef STREAM_ARB_STATS_EN
        check(grant_cnt_1 == 0 && grant_cnt_2 == 0 && drop_cnt == 0, "rst_stats",
              {grant_cnt_1, drop_cnt}, 0);
`endif

        // Both sources streaming, consumer free: strict alternation starting with source 1.
        do_reset();
        expect_ids('{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23, 8'h14, 8'h24});
        for (int t = 0; t < 4; t++) begin
            drive1(1'b1, 8'h11 + 8'(t));
            drive2(1'b1, 8'h21 + 8'(t));
            tick();
        end
        idle_inputs();
        wait_drain("both_drain", 30);
        check(xfer_cyc.size() == 8 && (xfer_cyc[7] - xfer_cyc[0]) == 7, "both_no_gaps",
              xfer_cyc.size(), 8);
`ifdef STREAM_ARB_STATS_EN
        check(grant_cnt_1 == 16'd4 && grant_cnt_2 == 16'd4, "both_grant_cnt",
              {grant_cnt_1, grant_cnt_2}, {16'd4, 16'd4});
`endif

        // Source 1 alone: back-to-back output, never stalled.
        do_reset();
        expect_ids('{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16});
        stall_seen = 1'b0;
        for (int t = 0; t < 6; t++) begin
            drive1(1'b1, 8'h11 + 8'(t));
            stall_seen |= stall_1;
            tick();
        end
        idle_inputs();
        stall_seen |= stall_1;
        wait_drain("solo_drain", 30);
        check(stall_seen == 1'b0, "solo_stall_1", stall_seen, 0);
        check(xfer_cyc.size() == 6 && (xfer_cyc[5] - xfer_cyc[0]) == 5, "solo_no_gaps",
              xfer_cyc.size(), 6);

        // Consumer stalled 10 cycles with the output register already holding 20.
        do_reset();
        in_stall = 1'b1;
        expect_ids('{8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23, 8'h14, 8'h24});
        drive2(1'b1, 8'h20);
        tick();
        acc1 = 0;
        acc2 = 0;
        for (int t = 0; t < 10; t++) begin
            drive1(1'b1, 8'h11 + 8'(acc1));
            drive2(1'b1, 8'h21 + 8'(acc2));
            check(stall_1 == (acc1 >= 4), "stall_1_level", stall_1, (acc1 >= 4));
            check(stall_2 == (acc2 >= 4), "stall_2_level", stall_2, (acc2 >= 4));
            a1 = (acc1 < 4);
            a2 = (acc2 < 4);
            tick();
            if (a1) acc1++;
            if (a2) acc2++;
        end
        idle_inputs();
        in_stall = 1'b0;
        wait_drain("stall_release_drain", 40);

        // FIFO flush: FIFO1 = 13,14,15 behind held 12; flush 14 keeps only 13.
        do_reset();
        in_stall = 1'b1;
        expect_ids('{8'h12, 8'h13, 8'h16, 8'h17});
        for (int t = 0; t < 4; t++) begin
            drive1(1'b1, 8'h12 + 8'(t));
            tick();
        end
        idle_inputs();
        flush_1    = 1'b1;
        flush_id_1 = 8'h14;
        tick();
        flush_1 = 1'b0;
`ifdef STREAM_ARB_STATS_EN
        check(drop_cnt == 16'd2, "fifo_flush_drop_cnt", drop_cnt, 2);
`endif
        drive1(1'b1, 8'h16);
        tick();
        drive1(1'b1, 8'h17);
        tick();
        idle_inputs();
        in_stall = 1'b0;
        wait_drain("fifo_flush_drain", 30);

        // Output-register flush: held 14 is withdrawn and never transferred.
        do_reset();
        in_stall = 1'b1;
        drive1(1'b1, 8'h14);
        tick();
        idle_inputs();
        tick();
        check(out_valid == 1'b1 && out_id == 8'h14, "held_14", {out_valid, out_id}, {1'b1, 8'h14});
        flush_1    = 1'b1;
        flush_id_1 = 8'h14;
        tick();
        flush_1 = 1'b0;
        check(out_valid == 1'b0, "out_flush_valid", out_valid, 0);
`ifdef STREAM_ARB_STATS_EN
        check(drop_cnt == 16'd1, "out_flush_drop_cnt", drop_cnt, 1);
`endif
        in_stall = 1'b0;
        repeat (3) tick();
        check(xfer_cyc.size() == 0, "out_flush_no_xfer", xfer_cyc.size(), 0);
        expect_ids('{8'h15});
        drive1(1'b1, 8'h15);
        tick();
        idle_inputs();
        wait_drain("out_flush_drain", 20);

        // Non-matching flushes on source 2; a push carrying the flushed ID is dropped.
        do_reset();
        expect_ids('{8'h21, 8'h22, 8'h23, 8'h24});
        drive2(1'b1, 8'h21);
        tick();
        drive2(1'b1, 8'h22);
        flush_2 = 1'b1; flush_id_2 = 8'h2F;
        tick();
        drive2(1'b1, 8'h2E);
        flush_2 = 1'b1; flush_id_2 = 8'h2E;
        tick();
        flush_2 = 1'b0;
        drive2(1'b1, 8'h23);
        tick();
        drive2(1'b1, 8'h24);
        tick();
        idle_inputs();
        wait_drain("nomatch_drain", 30);
`ifdef STREAM_ARB_STATS_EN
        check(drop_cnt == 16'd1, "nomatch_drop_cnt", drop_cnt, 1);
`endif

        // Reset in the middle of a stalled, full stream.
        in_stall = 1'b1;
        xfer_cyc.delete();
        for (int t = 0; t < 5; t++) begin
            drive1(1'b1, 8'h11 + 8'(t));
            tick();
        end
        idle_inputs();
        check(stall_1 == 1'b1 && out_valid == 1'b1, "pre_reset_full", {stall_1, out_valid}, 2'b11);
        #2;
        reset = 1'b1;
        #1;
        check(out_valid == 1'b0 && out_id == '0 && out_address == '0 && out_src == 1'b0,
              "mid_reset_outputs", {out_valid, out_src, out_address, out_id}, 0);
        check(stall_1 == 1'b0, "mid_reset_stall_1", stall_1, 0);
        tick();
        reset    = 1'b0;
        in_stall = 1'b0;
        repeat (6) tick();
        check(xfer_cyc.size() == 0 && out_valid == 1'b0, "post_reset_empty",
              {xfer_cyc.size(), out_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
